adder_share_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one signed WIDTH-bit adder among NUM_REQ requesters.

---
 rtl/adder_share_arbiter_pkg.sv | 7 +
 rtl/adder_share_arbiter_signed_add_ovf.sv | 28 ++
 rtl/adder_share_arbiter.sv | 87 ++++++++
 tb/tb_adder_share_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// adder_share_arbiter_pkg: FSM states and default sizing shared by the arbiter and its adder
package adder_share_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, LATCH, EXEC, RESP} state_e;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/adder_share_arbiter_signed_add_ovf.sv
// adder_share_arbiter_signed_add_ovf: ripple-carry signed adder (cin=0) with overflow flag
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module signed_add_ovf #(
  parameter int WIDTH = adder_share_arbiter_pkg::DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             ovf_o
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b0;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (.a_i(a_i[i]), .b_i(b_i[i]), .c_i(c[i]), .s_o(sum_o[i]), .c_o(c[i+1]));
  end
  // carry into and out of the sign bit disagree exactly on signed overflow
  assign ovf_o = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sequencer sharing one signed adder among NUM_REQ requesters
module adder_share_arbiter
  import adder_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_flat,
  input  logic [NUM_REQ*WIDTH-1:0] b_flat,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     result_valid,
  output logic [WIDTH-1:0]         sum_out,
  output logic                     ovf_out,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);
  localparam int IDX_W = $clog2(NUM_REQ);
  state_e state_q, state_d;
  logic [IDX_W-1:0] rr_q, rr_d, win_q, win_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d, add_sum;
  logic ovf_q, ovf_d, add_ovf;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // first set request scanning p, p+1, ... with wrap; descending loop lets the nearest win
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IDX_W-1:0] p);
    int idx;
    rr_pick = p;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NUM_REQ;
      if (r[idx]) rr_pick = IDX_W'(idx);
    end
  endfunction

  signed_add_ovf #(.WIDTH(WIDTH)) u_add (.a_i(op_a_q), .b_i(op_b_q), .sum_o(add_sum), .ovf_o(add_ovf));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      win_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      sum_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      win_q <= win_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    state_d = (state_q == IDLE) ? (|req ? LATCH : IDLE) :
              (state_q == LATCH) ? EXEC :
              (state_q == EXEC) ? RESP : IDLE;
  end

  always_comb begin
    win_d = (state_q == IDLE && |req) ? rr_pick(req, rr_q) : win_q;
    op_a_d = (state_q == LATCH) ? a_flat[win_q*WIDTH +: WIDTH] : op_a_q;
    op_b_d = (state_q == LATCH) ? b_flat[win_q*WIDTH +: WIDTH] : op_b_q;
    sum_d = (state_q == EXEC) ? add_sum : sum_q;
    ovf_d = (state_q == EXEC) ? add_ovf : ovf_q;
    rr_d = (state_q == RESP) ? IDX_W'((int'(win_q) + 1) % NUM_REQ) : rr_q;
    cnt_d = (state_q == RESP && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_comb begin
    grant = (state_q == RESP) ? NUM_REQ'(1) << win_q : '0;
    result_valid = (state_q == RESP);
    busy = (state_q != IDLE);
  end

  assign sum_out = sum_q;
  assign ovf_out = ovf_q;
  assign op_count = cnt_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: randomized self-checking bench against a behavioural arbiter/adder model
module tb_adder_share_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [15:0] a_flat, b_flat;
  logic [3:0] grant, grant2;
  logic result_valid, result_valid2, ovf_out, ovf_out2, busy, busy2;
  logic [3:0] sum_out, sum_out2;
  logic [7:0] op_count;
  logic [1:0] op_count2;
  int n_checks = 0;
  int n_fail = 0;
  int ptr = 0;
  int ops = 0;

  always #5 clk = ~clk;

  adder_share_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .grant(grant), .result_valid(result_valid), .sum_out(sum_out), .ovf_out(ovf_out),
    .busy(busy), .op_count(op_count)
  );

  adder_share_arbiter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .req(req), .a_flat(a_flat), .b_flat(b_flat),
    .grant(grant2), .result_valid(result_valid2), .sum_out(sum_out2), .ovf_out(ovf_out2),
    .busy(busy2), .op_count(op_count2)
  );

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ptr = 0;
    ops = 0;
  endtask

  // one full request/response; caller guarantees the DUT is idle and operands are set
  task automatic run_op(input logic [3:0] r, input bit drop, input bit hold);
    int w, s;
    logic [3:0] es, ea, eb;
    logic eo;
    req = r;
    w = pick(r, ptr);
    ea = a_flat[w*4 +: 4];
    eb = b_flat[w*4 +: 4];
    s = int'($signed(ea)) + int'($signed(eb));
    eo = (s > 7) || (s < -8);
    es = 4'(s);
    for (int c = 1; c <= 3; c++) begin
      step();
      if (c == 1 && drop) req = '0;
      if (c == 2) begin
        a_flat = 16'($urandom);
        b_flat = 16'($urandom);
      end
      if (c < 3) begin
        n_checks++;
        if (grant !== 4'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL early_grant: grant=%b busy=%b, want grant=0000 busy=1 (step %0d)", grant, busy, c);
        end
      end
    end
    ops++;
    n_checks++;
    if (grant !== 4'(1 << w) || result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL grant: got grant=%b valid=%b, want %b valid=1", grant, result_valid, 4'(1 << w));
    end
    n_checks++;
    if (sum_out !== es || ovf_out !== eo) begin
      n_fail++;
      $display("FAIL sum req%0d: %0d+%0d got sum=%h ovf=%b, want sum=%h ovf=%b", w, $signed(ea), $signed(eb), sum_out, ovf_out, es, eo);
    end
    n_checks++;
    if (grant2 !== grant || sum_out2 !== es) begin
      n_fail++;
      $display("FAIL dut2_op: grant2=%b sum2=%h, want grant2=%b sum2=%h", grant2, sum_out2, 4'(1 << w), es);
    end
    ptr = (w + 1) % 4;
    if (!hold) req = '0;
    step();
    n_checks++;
    if (grant !== 4'b0 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL pulse_len: grant=%b valid=%b one cycle after RESP, want 0000/0", grant, result_valid);
    end
    n_checks++;
    if (op_count !== 8'(ops > 255 ? 255 : ops) || op_count2 !== 2'(ops > 3 ? 3 : ops)) begin
      n_fail++;
      $display("FAIL op_count: got %0d/%0d, want %0d/%0d", op_count, op_count2, (ops > 255 ? 255 : ops), (ops > 3 ? 3 : ops));
    end
  endtask

  task automatic test_reset();
    req = '0;
    a_flat = 16'($urandom);
    b_flat = 16'($urandom);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (grant !== 4'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_quiet: grant=%b busy=%b valid=%b, want 0000/0/0", grant, busy, result_valid);
      end
    end
    n_checks++;
    if (op_count !== 8'd0 || sum_out !== 4'd0 || ovf_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: op_count=%0d sum=%h ovf=%b, want 0/0/0", op_count, sum_out, ovf_out);
    end
  endtask

  task automatic test_single();
    a_flat[3:0] = 4'd3;
    b_flat[3:0] = 4'd2;
    run_op(4'b0001, 1'b0, 1'b0);
    n_checks++;
    if (sum_out !== 4'd5 || ovf_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sum_hold: sum=%h ovf=%b after RESP, want 5/0", sum_out, ovf_out);
    end
  endtask

  task automatic test_overflow();
    a_flat[11:8] = 4'd7;
    b_flat[11:8] = 4'd1;
    run_op(4'b0100, 1'b0, 1'b0);
    a_flat[11:8] = 4'h8;
    b_flat[11:8] = 4'hF;
    run_op(4'b0100, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 5; i++) run_op(4'b1111, 1'b0, i < 4);
  endtask

  task automatic test_abort();
    a_flat = 16'($urandom);
    b_flat = 16'($urandom);
    req = 4'b0100;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = '0;
    ptr = 0;
    ops = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (grant !== 4'b0 || busy !== 1'b0 || op_count !== 8'd0) begin
        n_fail++;
        $display("FAIL abort: grant=%b busy=%b op_count=%0d, want 0000/0/0", grant, busy, op_count);
      end
      step();
    end
    run_op(4'b1111, 1'b0, 1'b0);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 5; i++) run_op(4'b1111, 1'b0, i < 4);
    run_op(4'b0010, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      a_flat = 16'($urandom);
      b_flat = 16'($urandom);
      run_op(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    a_flat = '0;
    b_flat = '0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
